// File: rtl/control_multi.sv
// Moore control unit for the shared-memory, single-ALU multi-cycle MIPS datapath.
// State is registered; every control output is a decode of the state, gated by mem_ready only in FETCH.
module control_multi (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [5:0] OP_RFORMAT = 6'd0;
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_ADDI    = 6'd8;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_SW      = 6'd43;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd15;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [3:0] decode_state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_next = S_MEMADR;
                    OP_RFORMAT:     state_next = S_EXEC;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J:           state_next = S_JUMP;
                    OP_ADDI:        state_next = S_ADDIEX;
                    default:        state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_RWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    // Outputs show FETCH values while reset is held, even before the reset edge lands.
    assign decode_state = reset_n ? state_reg : S_FETCH;
    assign state        = state_reg;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        illegal     = 1'b0;
        case (decode_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (opcode == OP_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_multi.sv
// Directed-vector bench: stimulus pushes per-cycle expected state/controls, a monitor pops and compares.
module tb_control_multi;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite;
    logic       MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, illegal;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctl;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    logic stim_done = 1'b0;

    control_multi dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .state(state), .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packing: PCWrite,PCWriteCond,BranchNE,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
    // ALUSrcA,RegWrite,RegDst,PCSource[2],ALUOp[2],ALUSrcB[2],illegal
    function automatic logic [17:0] exp_ctl(input logic [3:0] s, input logic mr,
                                            input logic [5:0] op, input logic rn);
        logic pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill;
        logic [1:0] pcs, aop, asb;
        logic [3:0] es;
        es = rn ? s : 4'd0;
        {pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (es)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  asb = 2'b11;
            4'd2, 4'd10: begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd11: rw = 1;
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (op == 6'd5); end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd15: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, aop, asb, ill};
    endfunction

    // One cycle: s is the state the previous edge should have produced.
    task automatic cyc(input logic [3:0] s, input logic mr, input logic [5:0] op, input logic rn);
        exp_t e;
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        reset_n   = rn;
        e.st  = s;
        e.ctl = exp_ctl(s, mr, op, rn);
        e.idx = cyc_no;
        cyc_no++;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [5:0] op, input int n, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4);
        logic [3:0] sl [5];
        sl[0] = s0; sl[1] = s1; sl[2] = s2; sl[3] = s3; sl[4] = s4;
        for (int i = 0; i < n; i++) cyc(sl[i], 1'b1, op, 1'b1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [17:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, MemtoReg,
                       IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal};
                checks++;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL state cyc=%0d actual=%0d required=%0d", e.idx, state, e.st);
                end
                checks++;
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL controls cyc=%0d state=%0d actual=%b required=%b",
                             e.idx, e.st, act, e.ctl);
                end
                $display("cyc %0d: state=%0d ctl=%b", e.idx, state, act);
            end
        end
    end

    initial begin
        reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
        // reset, then the seven-instruction sequence
        cyc(4'd0, 1'b1, 6'd0, 1'b0);
        cyc(4'd0, 1'b1, 6'd0, 1'b0);
        run(6'd0,  4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0);
        run(6'd35, 5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        run(6'd43, 4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0);
        run(6'd4,  3, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0);
        run(6'd5,  3, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0);
        run(6'd2,  3, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0);
        run(6'd8,  4, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0);
        // LW with 3 FETCH waits: 8 cycles
        for (int i = 0; i < 3; i++) cyc(4'd0, 1'b0, 6'd35, 1'b1);
        run(6'd35, 5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
        // LW with 3 MEMRD waits
        run(6'd35, 3, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) cyc(4'd3, 1'b0, 6'd35, 1'b1);
        cyc(4'd3, 1'b1, 6'd35, 1'b1);
        cyc(4'd4, 1'b1, 6'd35, 1'b1);
        // SW with 3 MEMWR waits
        run(6'd43, 3, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) cyc(4'd5, 1'b0, 6'd43, 1'b1);
        cyc(4'd5, 1'b1, 6'd43, 1'b1);
        // add with mem_ready low outside memory states: no effect
        cyc(4'd0, 1'b1, 6'd0, 1'b1);
        cyc(4'd1, 1'b0, 6'd0, 1'b1);
        cyc(4'd6, 1'b0, 6'd0, 1'b1);
        cyc(4'd7, 1'b0, 6'd0, 1'b1);
        // reset mid-LW in MEMRD for 2 edges, release, one FETCH wait
        run(6'd35, 3, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0);
        cyc(4'd3, 1'b0, 6'd35, 1'b0);
        cyc(4'd0, 1'b0, 6'd35, 1'b0);
        cyc(4'd0, 1'b0, 6'd35, 1'b1);
        cyc(4'd0, 1'b1, 6'd35, 1'b1);
        cyc(4'd1, 1'b1, 6'd35, 1'b1);
        cyc(4'd2, 1'b1, 6'd35, 1'b1);
        cyc(4'd3, 1'b1, 6'd35, 1'b1);
        cyc(4'd4, 1'b1, 6'd35, 1'b1);
        // illegal opcode: stuck in TRAP until reset
        cyc(4'd0, 1'b1, 6'd63, 1'b1);
        cyc(4'd1, 1'b1, 6'd63, 1'b1);
        for (int i = 0; i < 12; i++) cyc(4'd15, i[0], 6'd63, 1'b1);
        cyc(4'd15, 1'b1, 6'd63, 1'b0);
        run(6'd8, 5, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0);
        repeat (2) @(negedge clk);
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done == 1'b1 || cyc_no > 5000);
        checks++;
        if (!stim_done || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=%0d cycles required=completion", cyc_no);
        $fatal(1, "timeout");
    end

endmodule
